mmio_tx_port: RTL and testbench
===============================

MMIO_TX_PORT -- requirements
Module: mmio_tx_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 2..255.
REQ-002 SHALL have parameter TX_ADDR, default 32'h0000_00F0: TX data register address.
REQ-003 SHALL have parameter STAT_ADDR, default 32'h0000_00F4: status/control register address.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-006 SHALL have port we  input  1  store strobe from the core (mem_write).
REQ-007 SHALL have port addr  input  32  byte address from the core (alu_result).
REQ-008 SHALL have port wd  input  32  store data from the core (write_data).
REQ-009 SHALL have port rd  output  32  combinational read data returned to the core.
REQ-010 SHALL have port tx  output  1  registered serial line, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-012 SHALL hold a 4-entry, 8-bit FIFO with wrap-around read/write pointers and a 3-bit count.
REQ-013 SHALL push wd[7:0] on a rising edge where we=1, addr==TX_ADDR and count<4 at the start of that cycle.
REQ-014 SHALL drop a push when count==4 at cycle start, even if a pop occurs in the same cycle, and set sticky bit ovf.
REQ-015 SHALL clear ovf when we=1, addr==STAT_ADDR and wd[0]=1; a same-cycle overflow takes precedence and leaves ovf=1.
REQ-016 SHALL drive rd = {28'b0, ovf, busy, full, empty} when addr==STAT_ADDR, regardless of we; full=(count==4), empty=(count==0).
REQ-017 SHALL drive rd = 32'b0 for every other address, including TX_ADDR; writes to other addresses are ignored.
REQ-018 SHALL run a serializer FSM with states IDLE, START, DATA, STOP.
REQ-019 SHALL, in IDLE with count>0 at cycle start, pop the head into an 8-bit shift register and enter START on the next edge.
REQ-020 SHALL allow a push and a pop in the same cycle; count is unchanged and both take effect.
REQ-021 SHALL NOT pop when count==0 at cycle start; a push into an empty FIFO is popped no earlier than the following cycle.
REQ-022 SHALL drive tx=0 in START for CLKS_PER_BIT cycles, then enter DATA.
REQ-023 SHALL shift out 8 data bits LSB first in DATA, each held CLKS_PER_BIT cycles, using a 3-bit bit index and an 8-bit baud counter.
REQ-024 SHALL drive tx=1 in STOP for CLKS_PER_BIT cycles, then return to IDLE; IDLE lasts at least one cycle between frames.
REQ-025 SHALL give frame spacing of 10*CLKS_PER_BIT+1 cycles for back-to-back bytes.
REQ-026 SHALL drive tx=1 in IDLE.
REQ-027 SHALL drive busy = (state!=IDLE) | (count!=0).

Reset
REQ-028 SHALL, on reset=0, immediately set state=IDLE, tx=1, FIFO pointers=0, count=0, ovf=0, baud counter=0 and bit index=0.
REQ-029 SHALL, on reset=0, drive busy=0 and rd status value 32'h1 (empty), independent of clk.
REQ-030 SHALL abort any in-progress frame when reset is asserted mid-frame; tx returns high without completing the frame.
REQ-031 SHALL discard FIFO contents on reset.
REQ-032 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-033 Reset: hold reset=0 for 2 cycles, then release -> tx=1, busy=0, rd at 0xF4 = 32'h1.
REQ-034 Single byte: write 32'h0000_00A5 to 0xF0 with CLKS_PER_BIT=4 -> tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; busy falls after STOP.
REQ-035 Overflow: write 6 bytes 0x01..0x06 on consecutive cycles -> 0x01 pops and 0x02..0x05 fill the FIFO; 0x06 is dropped; ovf=1; rd at 0xF4 = 32'h0000_000E; the line carries 0x01..0x05 in order.
REQ-036 Overflow clear: after REQ-035, write 32'h1 to 0xF4 -> ovf=0; the same write issued in a cycle with a dropped push -> ovf stays 1.
REQ-037 Back-to-back: write 0x55 and 0xAA consecutively -> the second START falling edge occurs 41 cycles after the first; bit order is LSB first.
REQ-038 Mid-frame reset: assert reset=0 during the DATA state of a frame carrying 0x3C -> tx=1 and busy=0 immediately; the remaining bits are never emitted.

Source files
------------

// File: rtl/mmio_tx_port.sv
// Memory-mapped serial transmit port.
// A store to TX_ADDR queues a byte in a 4-entry FIFO. The serializer sends
// each byte as a frame: one start bit (0), eight data bits LSB first, and
// one stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
// Status register at STAT_ADDR reads as {28'b0, ovf, busy, full, empty}.
// Writing it with wd[0]=1 clears the sticky overflow flag.
// Ports:
//   clk   - clock; all state updates on its rising edge
//   reset - asynchronous reset, active low
//   we    - store strobe from the core
//   addr  - byte address from the core
//   wd    - store data from the core
//   rd    - combinational read data returned to the core
//   tx    - registered serial line, idle high
//   busy  - a frame is on the line or the FIFO holds data
module mmio_tx_port #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [31:0] TX_ADDR      = 32'h0000_00F0,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_00F4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [DATA_W-1:0] r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit_idx;
  logic              r_tx;

  logic              w_full;
  logic              w_empty;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic              w_clr;
  logic              w_pop;
  logic              w_baud_done;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [BIT_W-1:0]  w_bit_idx_nxt;
  logic              w_tx_nxt;
  logic              w_unused_wd;

  // Only the low byte is transmitted; bit 0 doubles as the clear request.
  assign w_unused_wd = ^wd[31:DATA_W];

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push_req  = we && (addr == TX_ADDR);
  assign w_push      = w_push_req && !w_full;
  // A full FIFO drops the store even if a pop frees a slot this cycle.
  assign w_drop      = w_push_req && w_full;
  assign w_clr       = we && (addr == STAT_ADDR) && wd[0];
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop)     r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= wd[DATA_W-1:0];
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Serializer next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_START;
      S_START: if (w_baud_done) w_state_nxt = S_DATA;
      S_DATA:  if (w_baud_done && (r_bit_idx == BIT_LAST)) w_state_nxt = S_STOP;
      S_STOP:  if (w_baud_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Baud counter and bit index; the index wraps to 0 after the last data bit.
  always_comb begin
    w_baud_nxt    = '0;
    w_bit_idx_nxt = r_bit_idx;
    if ((r_state != S_IDLE) && !w_baud_done) w_baud_nxt = r_baud + BAUD_W'(1);
    if ((r_state == S_DATA) && w_baud_done)  w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
  end

  // Line level for the state being entered, so tx changes with the state.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = r_shift[w_bit_idx_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Serializer datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      if (w_pop) r_shift <= r_fifo[r_rd_ptr];
      r_tx      <= w_tx_nxt;
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != S_IDLE) || !w_empty;

  // Status read; every other address reads as zero.
  always_comb begin
    rd = '0;
    if (addr == STAT_ADDR) rd = {28'b0, r_ovf, busy, w_full, w_empty};
  end

endmodule

// File: tb/tb_mmio_tx_port.sv
// Bench for mmio_tx_port: directed and random stores and reads.
// A queue-based reference model predicts status reads and the byte order
// on the line. A line monitor decodes frames and checks each one against
// the scoreboard queue.
module tb_mmio_tx_port;

  localparam int CPB = 4;
  localparam logic [31:0] TX_A = 32'h0000_00F0;
  localparam logic [31:0] ST_A = 32'h0000_00F4;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int frames_seen = 0;

  // Reference model: FIFO as a queue, serializer as remaining frame cycles.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         starts[$];
  int         ser_left = 0;
  logic       movf = 1'b0;

  logic mon_smp [10*CPB];

  mmio_tx_port #(
    .CLKS_PER_BIT(CPB),
    .TX_ADDR     (TX_A),
    .STAT_ADDR   (ST_A)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .rd   (rd),
    .tx   (tx),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_busy();
    return (ser_left != 0) || (mq.size() != 0);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a != ST_A) return 32'h0;
    return {28'b0, movf, model_busy(), mq.size() == 4, mq.size() == 0};
  endfunction

  // Advance the model across one rising edge using cycle-start values.
  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    int  sz;
    logic pop;
    logic push_req;
    sz       = mq.size();
    pop      = (ser_left == 0) && (sz > 0);
    push_req = w && (a == TX_A);
    if (pop) exp_q.push_back(mq.pop_front());
    if (push_req && sz < 4) mq.push_back(d[7:0]);
    if (push_req && sz == 4)                movf = 1'b1;
    else if (w && (a == ST_A) && d[0])      movf = 1'b0;
    if (pop)               ser_left = 10 * CPB;
    else if (ser_left > 0) ser_left = ser_left - 1;
  endtask

  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w;
    addr = a;
    wd = d;
    #1;
    check("rd", rd, model_rd(a));
    check("busy", 32'(busy), 32'(model_busy()));
    model_step(w, a, d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || ser_left != 0) && n < 3000) begin
      cycle(1'b0, ST_A, 32'h0);
      n++;
    end
    check("drain_bound", 32'(n < 3000), 32'h1);
    repeat (3) cycle(1'b0, ST_A, 32'h0);
  endtask

  // Line monitor: collects 10*CPB samples after a falling edge, then decodes.
  initial begin : monitor
    int   n;
    logic act;
    logic shape_ok;
    logic [7:0] b;
    act = 1'b0;
    n   = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 1'b0;
        n   = 0;
      end else if (!act) begin
        if (tx == 1'b0) begin
          act = 1'b1;
          mon_smp[0] = tx;
          n = 1;
          starts.push_back(cyc);
        end
      end else begin
        mon_smp[n] = tx;
        n++;
        if (n == 10 * CPB) begin
          act = 1'b0;
          shape_ok = 1'b1;
          b = 8'h00;
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < CPB; j++)
              if (mon_smp[k*CPB+j] !== mon_smp[k*CPB]) shape_ok = 1'b0;
          if (mon_smp[0] !== 1'b0 || mon_smp[9*CPB] !== 1'b1) shape_ok = 1'b0;
          for (int k = 0; k < 8; k++) b[k] = mon_smp[(k+1)*CPB];
          frames_seen++;
          check("frame_shape", 32'(shape_ok), 32'h1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL frame_unexpected: got 0x%02h expected no frame", b);
          end else begin
            check("frame_data", 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int f0;
    reset = 1'b1;
    we    = 1'b0;
    addr  = ST_A;
    wd    = 32'h0;

    // Reset: asynchronous, checked before any clock edge and while held.
    #2 reset = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rd", rd, 32'h1);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_hold_tx", 32'(tx), 32'h1);
      check("rst_hold_rd", rd, 32'h1);
    end
    reset = 1'b1;
    cycle(1'b0, ST_A, 32'h0);
    check("post_rst_rd", rd, 32'h1);
    check("post_rst_tx", 32'(tx), 32'h1);
    cycle(1'b0, TX_A, 32'h0);
    check("rd_tx_addr_zero", rd, 32'h0);

    // Single byte.
    cycle(1'b1, TX_A, 32'h0000_00A5);
    drain();

    // Overflow: 0x06 is dropped, status shows ovf|busy|full.
    for (int i = 1; i <= 6; i++) cycle(1'b1, TX_A, 32'(i));
    cycle(1'b0, ST_A, 32'h0);
    check("ovf_status", rd, 32'h0000_000E);
    cycle(1'b1, ST_A, 32'hFFFF_FFFE);
    cycle(1'b0, ST_A, 32'h0);
    check("ovf_no_clear_bit0_low", rd, 32'h0000_000E);
    cycle(1'b1, ST_A, 32'h1);
    cycle(1'b0, ST_A, 32'h0);
    check("ovf_cleared", rd, 32'h0000_0006);
    drain();

    // Back-to-back frame spacing.
    starts.delete();
    cycle(1'b1, TX_A, 32'h55);
    cycle(1'b1, TX_A, 32'hAA);
    drain();
    check("b2b_frames", 32'(starts.size()), 32'h2);
    if (starts.size() == 2) check("b2b_spacing", 32'(starts[1] - starts[0]), 32'(10 * CPB + 1));

    // Mid-frame reset during the data bits of 0x3C.
    f0 = frames_seen;
    cycle(1'b1, TX_A, 32'h3C);
    repeat (1 + CPB + 3 * CPB) cycle(1'b0, ST_A, 32'h0);
    check("mid_busy_before", 32'(busy), 32'h1);
    @(negedge clk);
    #2;
    we = 1'b0;
    addr = ST_A;
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'h1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_rd", rd, 32'h1);
    mq.delete();
    exp_q.delete();
    ser_left = 0;
    movf = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("mid_hold_tx", 32'(tx), 32'h1);
    end
    reset = 1'b1;
    repeat (60) cycle(1'b0, ST_A, 32'h0);
    check("mid_no_frame", 32'(frames_seen), 32'(f0));

    // Random traffic: a dense phase that overflows, then a sparse phase.
    for (int i = 0; i < 800; i++) begin
      int unsigned sel;
      int unsigned thr;
      logic [31:0] ra;
      logic [31:0] rdat;
      sel  = $urandom_range(0, 99);
      thr  = (i < 400) ? 40 : 6;
      rdat = $urandom;
      ra   = $urandom & 32'hFFFF_FFFC;
      if (ra == TX_A || ra == ST_A) ra = 32'h0000_0100;
      if (sel < thr)       cycle(1'b1, TX_A, rdat);
      else if (sel < 50)   cycle(1'b1, ST_A, rdat);
      else if (sel < 70)   cycle(1'b0, ST_A, rdat);
      else if (sel < 80)   cycle(1'b0, TX_A, rdat);
      else if (sel < 90)   cycle(1'b0, ra, rdat);
      else                 cycle(1'b1, ra, rdat);
    end
    drain();
    check("all_frames_seen", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
